dmem_responder: RTL
===================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter XLEN, default 32, data and address width.
REQ-002 SHALL have parameter DMEM_SIZE, default 1024, memory depth in 32-bit words.
REQ-003 SHALL have parameter WAIT_CYCLES, default 1, added access latency in cycles (0..15).
REQ-004 SHALL have port clk_i  in  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst_i  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port req_valid_i  in  1  request present.
REQ-007 SHALL have port req_ready_o  out  1  responder can accept request.
REQ-008 SHALL have port req_we_i  in  1  1 = store, 0 = load.
REQ-009 SHALL have port req_addr_i  in  XLEN  byte address.
REQ-010 SHALL have port req_size_i  in  2  access size, mem_size_e encoding: MEM_BYTE 00, MEM_HALFW 01, MEM_WORD 10.
REQ-011 SHALL have port req_unsigned_i  in  1  load zero-extends (LBU/LHU) when 1.
REQ-012 SHALL have port req_wdata_i  in  XLEN  store data, right-aligned.
REQ-013 SHALL have port rsp_valid_o  out  1  response present.
REQ-014 SHALL have port rsp_ready_i  in  1  requester accepts response.
REQ-015 SHALL have port rsp_rdata_o  out  XLEN  load data, extended; 0 for stores and errors.
REQ-016 SHALL have port rsp_err_o  out  1  access error, valid with rsp_valid_o.

Function
REQ-017 SHALL implement states IDLE, WAIT, RESP; req_ready_o = 1 only in IDLE.
REQ-018 SHALL, in IDLE with req_valid_i = 1, latch we/addr/size/unsigned/wdata and go to WAIT (WAIT_CYCLES > 0) or RESP (WAIT_CYCLES = 0).
REQ-019 SHALL stay in WAIT exactly WAIT_CYCLES cycles via a down-counter, then enter RESP; request inputs ignored outside IDLE.
REQ-020 SHALL perform memory access on the edge entering RESP: store updates only selected byte lanes; load result registered into rsp_rdata_o.
REQ-021 SHALL select lanes: byte -> lane addr[1:0]; halfword -> lanes addr[1]*2..+1; word -> all four; store writes low bytes of wdata to those lanes.
REQ-022 SHALL sign-extend byte/halfword loads from the lane MSB unless req_unsigned_i = 1, then zero-extend; word loads unmodified.
REQ-023 SHALL flag error when addr[XLEN-1:2] >= DMEM_SIZE or req_size_i = 11; erroring store writes nothing, rdata = 0.
REQ-024 SHALL hold rsp_valid_o, rsp_rdata_o, rsp_err_o stable in RESP until rsp_ready_i = 1, then return to IDLE next cycle.
REQ-025 SHALL not accept a new request in the cycle the response handshake completes; minimum request-to-request spacing = WAIT_CYCLES + 2 cycles.
REQ-026 SHALL give response latency: rsp_valid_o rises WAIT_CYCLES + 1 cycles after the accepting edge.
REQ-027 SHALL, for a load following a store to the same word, return the newly written data.

Reset
REQ-028 SHALL, while rst_i = 1 at a clock edge, set state IDLE, counter 0, rsp_valid_o 0, rsp_rdata_o 0, rsp_err_o 0; req_ready_o = 1 after the reset edge.
REQ-029 SHALL discard an in-flight request on reset in WAIT or RESP; pending store does not modify memory.
REQ-030 SHALL not reset memory contents.

Configuration
REQ-031 SHALL use macro DMEM_MISALIGN_ERR_EN: defined -> halfword with addr[0] = 1 or word with addr[1:0] != 00 raises rsp_err_o, no write, rdata 0.
REQ-032 SHALL, without DMEM_MISALIGN_ERR_EN, force misaligned addresses down to size alignment (clear addr[0] for halfword, addr[1:0] for word) and complete without error.

Verification
REQ-033 SHALL cover: store word 0xDEADBEEF at 0x10, load word 0x10 -> rdata 0xDEADBEEF, err 0, rsp_valid_o WAIT_CYCLES+1 cycles after accept.
REQ-034 SHALL cover: after REQ-033, load byte 0x13 signed -> 0xFFFFFFDE; unsigned -> 0x000000DE; load half 0x10 signed -> 0xFFFFBEEF.
REQ-035 SHALL cover: store byte 0x55 at 0x11 over 0xDEADBEEF, load word 0x10 -> 0xDEAD55EF.
REQ-036 SHALL cover: load word at 0x1000 (DMEM_SIZE 1024) -> err 1, rdata 0; load half at 0x11 -> err 1 with macro, data of 0x10 without.
REQ-037 SHALL cover: rsp_ready_i held 0 for 5 cycles -> rsp_valid_o/rdata stable, req_ready_o 0; release -> IDLE next cycle.
REQ-038 SHALL cover: rst_i asserted in WAIT of store 0x12345678 to 0x20 -> outputs reset, later load 0x20 returns prior contents.

Source files
------------

// File: rtl/dmem_if.sv
// dmem_if -- request/response bus between a load/store requester and the
// data memory responder.
//
// Handshake: a transfer on either channel happens on a rising clock edge
// where valid and ready are both 1. The source holds valid and its payload
// steady until that edge. The sink may raise or lower ready freely.
//
// Parameters: XLEN -- data and address width.
// Request channel (requester -> responder): req_valid_i, req_we_i,
//   req_addr_i, req_size_i, req_unsigned_i, req_wdata_i; back: req_ready_o.
// Response channel (responder -> requester): rsp_valid_o, rsp_rdata_o,
//   rsp_err_o; back: rsp_ready_i.
// Modports: master (requester side), slave (responder side).
interface dmem_if #(
    parameter int XLEN = 32
);
    logic            req_valid_i;
    logic            req_ready_o;
    logic            req_we_i;
    logic [XLEN-1:0] req_addr_i;
    logic [1:0]      req_size_i;
    logic            req_unsigned_i;
    logic [XLEN-1:0] req_wdata_i;
    logic            rsp_valid_o;
    logic            rsp_ready_i;
    logic [XLEN-1:0] rsp_rdata_o;
    logic            rsp_err_o;

    modport master (
        output req_valid_i, req_we_i, req_addr_i, req_size_i, req_unsigned_i,
               req_wdata_i, rsp_ready_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
    );

    modport slave (
        input  req_valid_i, req_we_i, req_addr_i, req_size_i, req_unsigned_i,
               req_wdata_i, rsp_ready_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
    );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder -- single-outstanding data memory with byte/half/word
// loads and stores, a fixed access latency and registered responses.
//
// Parameters: XLEN (data/address width, memory words are 32 bits),
//   DMEM_SIZE (depth in 32-bit words), WAIT_CYCLES (extra latency, 0..15).
// Ports: clk_i, rst_i (synchronous, active-high); bus (dmem_if.slave) with
//   the request and response channels; state_o exposes the FSM state
//   (0 IDLE, 1 WAIT, 2 RESP) for observation.
// Build option: define DMEM_MISALIGN_ERR_EN to report misaligned halfword/
//   word accesses as errors; otherwise the address is forced down to the
//   natural alignment of the access size and the access completes.
module dmem_responder #(
    parameter int XLEN        = 32,
    parameter int DMEM_SIZE   = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic       clk_i,
    input  logic       rst_i,
    dmem_if.slave      bus,
    output logic [1:0] state_o
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam int              AW         = (DMEM_SIZE > 1) ? $clog2(DMEM_SIZE) : 1;
    localparam logic [3:0]      WAIT_LOAD  = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
    localparam logic [XLEN-3:0] WORD_LIMIT = (XLEN-2)'(DMEM_SIZE);

    logic [1:0]      state;
    logic [3:0]      cnt;
    logic            lat_we;
    logic [XLEN-1:0] lat_addr;
    logic [1:0]      lat_size;
    logic            lat_unsigned;
    logic [XLEN-1:0] lat_wdata;
    logic            rsp_valid;
    logic [XLEN-1:0] rsp_rdata;
    logic            rsp_err;

    logic [31:0] mem [DMEM_SIZE];

    // Access operands: with WAIT_CYCLES = 0 the access happens on the
    // accepting edge itself, so the live request is used; otherwise the
    // latched copy is used.
    logic            acc_we;
    logic [XLEN-1:0] acc_addr;
    logic [1:0]      acc_size;
    logic            acc_unsigned;
    logic [XLEN-1:0] acc_wdata;
    logic [XLEN-1:0] eff_addr;
    logic            acc_err;
    logic            enter_resp;
    logic            mem_we;
    logic [AW-1:0]   widx;
    logic [3:0]      lane_mask;
    logic [31:0]     wword;
    logic [31:0]     rword;
    logic [31:0]     shifted;
    logic [31:0]     load_val;

    always_comb begin
        if (state == ST_IDLE) begin
            acc_we       = bus.req_we_i;
            acc_addr     = bus.req_addr_i;
            acc_size     = bus.req_size_i;
            acc_unsigned = bus.req_unsigned_i;
            acc_wdata    = bus.req_wdata_i;
        end else begin
            acc_we       = lat_we;
            acc_addr     = lat_addr;
            acc_size     = lat_size;
            acc_unsigned = lat_unsigned;
            acc_wdata    = lat_wdata;
        end
    end

    always_comb begin
        eff_addr = acc_addr;
        if (acc_size == 2'b01) eff_addr[0] = 1'b0;
        if (acc_size == 2'b10) eff_addr[1:0] = 2'b00;
        acc_err = (acc_size == 2'b11) || (acc_addr[XLEN-1:2] >= WORD_LIMIT);
`ifdef DMEM_MISALIGN_ERR_EN
        if (acc_size == 2'b01 && acc_addr[0]) acc_err = 1'b1;
        if (acc_size == 2'b10 && acc_addr[1:0] != 2'b00) acc_err = 1'b1;
`endif
    end

    always_comb begin
        enter_resp = 1'b0;
        if (state == ST_IDLE && bus.req_valid_i && WAIT_CYCLES == 0) enter_resp = 1'b1;
        if (state == ST_WAIT && cnt == 4'd0) enter_resp = 1'b1;
    end

    assign widx    = eff_addr[AW+1:2];
    assign rword   = mem[widx];
    assign shifted = rword >> {eff_addr[1:0], 3'b000};
    // A reset on the same edge cancels the pending store.
    assign mem_we  = enter_resp && acc_we && !acc_err && !rst_i;

    always_comb begin
        lane_mask = 4'b0000;
        wword     = acc_wdata[31:0];
        load_val  = rword;
        unique case (acc_size)
            2'b00: begin
                lane_mask = 4'b0001 << eff_addr[1:0];
                wword     = {4{acc_wdata[7:0]}};
                load_val  = acc_unsigned ? {24'd0, shifted[7:0]}
                                         : {{24{shifted[7]}}, shifted[7:0]};
            end
            2'b01: begin
                lane_mask = eff_addr[1] ? 4'b1100 : 4'b0011;
                wword     = {2{acc_wdata[15:0]}};
                load_val  = acc_unsigned ? {16'd0, shifted[15:0]}
                                         : {{16{shifted[15]}}, shifted[15:0]};
            end
            2'b10: begin
                lane_mask = 4'b1111;
            end
            default: begin
                lane_mask = 4'b0000;
            end
        endcase
    end

    // Memory contents are deliberately left out of reset.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            for (int l = 0; l < 4; l++) begin
                if (lane_mask[l]) mem[widx][8*l +: 8] <= wword[8*l +: 8];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= ST_IDLE;
            cnt          <= 4'd0;
            rsp_valid    <= 1'b0;
            rsp_rdata    <= '0;
            rsp_err      <= 1'b0;
            lat_we       <= 1'b0;
            lat_addr     <= '0;
            lat_size     <= 2'b00;
            lat_unsigned <= 1'b0;
            lat_wdata    <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (bus.req_valid_i) begin
                        lat_we       <= bus.req_we_i;
                        lat_addr     <= bus.req_addr_i;
                        lat_size     <= bus.req_size_i;
                        lat_unsigned <= bus.req_unsigned_i;
                        lat_wdata    <= bus.req_wdata_i;
                        if (WAIT_CYCLES == 0) begin
                            state <= ST_RESP;
                        end else begin
                            state <= ST_WAIT;
                            cnt   <= WAIT_LOAD;
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt == 4'd0) state <= ST_RESP;
                    else             cnt   <= cnt - 4'd1;
                end
                ST_RESP: begin
                    if (bus.rsp_ready_i) begin
                        state     <= ST_IDLE;
                        rsp_valid <= 1'b0;
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
            if (enter_resp) begin
                rsp_valid <= 1'b1;
                rsp_err   <= acc_err;
                rsp_rdata <= (acc_err || acc_we) ? '0 : XLEN'(load_val);
            end
        end
    end

    assign bus.req_ready_o = (state == ST_IDLE);
    assign bus.rsp_valid_o = rsp_valid;
    assign bus.rsp_rdata_o = rsp_rdata;
    assign bus.rsp_err_o   = rsp_err;
    assign state_o         = state;
endmodule
